// File: rtl/decodificacao_pipe.sv
// rtl/decodificacao_pipe.sv - RV32I decode stage with valid/ready handshake and 2-entry output buffer
// Optional macro: DECODIFICACAO_ILLEGAL_EN adds the registered 'illegal' output.
module decodificacao_pipe #(
  parameter int XLEN     = 32,
  parameter int IMM_MODE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] immediate,
  output logic [2:0]      tipo,
`ifdef DECODIFICACAO_ILLEGAL_EN
  output logic            illegal,
`endif
  output logic            negativo
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      tipo;
`ifdef DECODIFICACAO_ILLEGAL_EN
    logic            illegal;
`endif
    logic            negativo;
  } dec_t;

  // Pure combinational decode of one raw word into the registered field set.
  function automatic dec_t decode(input logic [31:0] instr);
    dec_t              d;
    logic signed [31:0] raw;
    logic [2:0]        f3;
    logic [6:0]        f7;
    d   = '0;
    raw = '0;
    f3  = instr[14:12];
    f7  = instr[31:25];
    d.opcode = instr[6:0];
    d.tipo   = 3'b111;
    case (instr[6:0])
      OP_R: begin
        d.tipo = 3'b000; d.rd = instr[11:7]; d.rs1 = instr[19:15];
        d.rs2 = instr[24:20]; d.funct3 = f3; d.funct7 = f7;
      end
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
        d.tipo = 3'b001; d.rd = instr[11:7]; d.rs1 = instr[19:15]; d.funct3 = f3;
        // Shift-immediates carry funct7 (srai vs srli) in the upper bits.
        if (instr[6:0] == OP_IMM && (f3 == 3'b001 || f3 == 3'b101)) d.funct7 = f7;
        raw = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        d.tipo = 3'b010; d.rs1 = instr[19:15]; d.rs2 = instr[24:20]; d.funct3 = f3;
        raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        d.tipo = 3'b011; d.rs1 = instr[19:15]; d.rs2 = instr[24:20]; d.funct3 = f3;
        raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        d.tipo = 3'b100; d.rd = instr[11:7];
        raw = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        d.tipo = 3'b101; d.rd = instr[11:7];
        raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: d.opcode = instr[6:0];
    endcase
    d.imm      = XLEN'(raw);
    d.negativo = (d.tipo != 3'b000 && d.tipo != 3'b111) ? instr[31] : 1'b0;
    // Sign-magnitude mode: a negative U immediate at XLEN=32 wraps to its unsigned magnitude.
    if (IMM_MODE == 1 && d.negativo) d.imm = -d.imm;
`ifdef DECODIFICACAO_ILLEGAL_EN
    d.illegal = (d.tipo == 3'b111) || (instr[1:0] != 2'b11);
    case (instr[6:0])
      OP_R:      if (!(f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
                   d.illegal = 1'b1;
      OP_STORE:  if (f3 > 3'b010) d.illegal = 1'b1;
      OP_BRANCH: if (f3 == 3'b010 || f3 == 3'b011) d.illegal = 1'b1;
      OP_LOAD:   if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) d.illegal = 1'b1;
      default:   d.illegal = d.illegal;
    endcase
`endif
    return d;
  endfunction

  dec_t        dec_q, dec_d;
  logic        out_valid_q, out_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  dec_t        in_dec, skid_dec;
  logic        accept, transfer;

  assign in_dec   = decode(in_instr);
  assign skid_dec = decode(skid_instr_q);
  assign accept   = in_valid && !skid_valid_q;
  assign transfer = out_valid_q && out_ready;

  // Buffer placement: output register first, skid register only when output is stalled.
  always_comb begin
    dec_d        = dec_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || transfer) begin
      if (skid_valid_q) begin
        // Skid full means in_ready was low, so nothing is accepted this edge.
        dec_d        = skid_dec;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        dec_d       = in_dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_instr_d = in_instr;
      skid_valid_d = 1'b1;
    end
  end

  // State registers; reset leaves fields zero and format unknown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q        <= '0;
      dec_q.tipo   <= 3'b111;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
    end else begin
      dec_q        <= dec_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign in_ready  = !skid_valid_q;
  assign out_valid = out_valid_q;
  assign opcode    = dec_q.opcode;
  assign rd        = dec_q.rd;
  assign rs1       = dec_q.rs1;
  assign rs2       = dec_q.rs2;
  assign funct3    = dec_q.funct3;
  assign funct7    = dec_q.funct7;
  assign immediate = dec_q.imm;
  assign tipo      = dec_q.tipo;
  assign negativo  = dec_q.negativo;
`ifdef DECODIFICACAO_ILLEGAL_EN
  assign illegal   = dec_q.illegal;
`endif

endmodule

// File: tb/tb_decodificacao_pipe.sv
// tb/tb_decodificacao_pipe.sv - directed bench for decodificacao_pipe (IMM_MODE 0 and 1 instances)
module tb_decodificacao_pipe;

  logic        clk, rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;

  logic        rdy0, vld0, neg0;
  logic [6:0]  op0, f7_0;
  logic [4:0]  rd0, rs1_0, rs2_0;
  logic [2:0]  f3_0, tipo0;
  logic [31:0] imm0;
  logic        rdy1, vld1, neg1;
  logic [6:0]  op1, f7_1;
  logic [4:0]  rd1, rs1_1, rs2_1;
  logic [2:0]  f3_1, tipo1;
  logic [31:0] imm1;
`ifdef DECODIFICACAO_ILLEGAL_EN
  logic        ill0, ill1;
`endif

  int errors = 0;
  int checks = 0;
  logic [4:0] mon_q[$];

  localparam logic [31:0] W_ADDI = 32'hFFF10093;
  localparam logic [31:0] W_LUI  = 32'h123452B7;
  localparam logic [31:0] W_ADD  = 32'h002081B3;
  localparam logic [31:0] W_SW   = 32'hFE20AE23;
  localparam logic [31:0] W_BEQ  = 32'hFE208CE3;
  localparam logic [31:0] W_JAL  = 32'h001000EF;
  localparam logic [31:0] W_SUBB = 32'h40001033;

  decodificacao_pipe #(.XLEN(32), .IMM_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_instr(in_instr), .out_valid(vld0), .out_ready(out_ready), .opcode(op0),
    .rd(rd0), .rs1(rs1_0), .rs2(rs2_0), .funct3(f3_0), .funct7(f7_0),
    .immediate(imm0), .tipo(tipo0),
`ifdef DECODIFICACAO_ILLEGAL_EN
    .illegal(ill0),
`endif
    .negativo(neg0));

  decodificacao_pipe #(.XLEN(32), .IMM_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_instr(in_instr), .out_valid(vld1), .out_ready(out_ready), .opcode(op1),
    .rd(rd1), .rs1(rs1_1), .rs2(rs2_1), .funct3(f3_1), .funct7(f7_1),
    .immediate(imm1), .tipo(tipo1),
`ifdef DECODIFICACAO_ILLEGAL_EN
    .illegal(ill1),
`endif
    .negativo(neg1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records rd of every word that leaves dut0, in order.
  always @(posedge clk) if (vld0 && out_ready) mon_q.push_back(rd0);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [31:0] w);
    @(negedge clk);
    in_valid = 1'b1; in_instr = w; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic fill_both;
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_instr = W_ADDI;
    @(posedge clk); #1;
    @(negedge clk); in_instr = W_LUI;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    checks++; if ({vld0, rdy0, vld1, rdy1} !== 4'b0101) begin errors++;
      $display("FAIL reset_hs: got %b want 0101", {vld0, rdy0, vld1, rdy1}); end
    checks++; if ({tipo0, tipo1} !== 6'b111111) begin errors++;
      $display("FAIL reset_tipo: got %b want 111111", {tipo0, tipo1}); end
    checks++; if ({op0, rd0, rs1_0, rs2_0, f3_0, f7_0, imm0, neg0} !== '0) begin errors++;
      $display("FAIL reset_fields: got op=%h rd=%0d imm=%h neg=%b want zeros", op0, rd0, imm0, neg0); end
  endtask

  task automatic test_formats;
    send(W_ADDI);
    checks++; if ({vld0, tipo0, rd0, rs1_0, rs2_0, f3_0, f7_0} !== {1'b1, 3'b001, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0}) begin errors++;
      $display("FAIL addi_fields: got v=%b tipo=%b rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h", vld0, tipo0, rd0, rs1_0, rs2_0, f3_0, f7_0); end
    checks++; if ({imm0, neg0} !== {32'hFFFFFFFF, 1'b1}) begin errors++;
      $display("FAIL addi_imm: got %h neg=%b want ffffffff neg=1", imm0, neg0); end
    checks++; if ({imm1, neg1} !== {32'h00000001, 1'b1}) begin errors++;
      $display("FAIL addi_imm_sm: got %h neg=%b want 00000001 neg=1", imm1, neg1); end
    send(W_LUI);
    checks++; if ({tipo0, rd0, rs1_0, f3_0, imm0, neg0} !== {3'b100, 5'd5, 5'd0, 3'd0, 32'h12345000, 1'b0}) begin errors++;
      $display("FAIL lui: got tipo=%b rd=%0d rs1=%0d imm=%h neg=%b", tipo0, rd0, rs1_0, imm0, neg0); end
    send(W_ADD);
    checks++; if ({tipo0, rd0, rs1_0, rs2_0, imm0, neg0} !== {3'b000, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0}) begin errors++;
      $display("FAIL add: got tipo=%b rd=%0d rs1=%0d rs2=%0d imm=%h", tipo0, rd0, rs1_0, rs2_0, imm0); end
    send(W_SW);
    checks++; if ({tipo0, rd0, rs1_0, rs2_0, f3_0, imm0} !== {3'b010, 5'd0, 5'd1, 5'd2, 3'd2, 32'hFFFFFFFC}) begin errors++;
      $display("FAIL sw: got tipo=%b rd=%0d rs1=%0d rs2=%0d f3=%0d imm=%h", tipo0, rd0, rs1_0, rs2_0, f3_0, imm0); end
    checks++; if ({imm1, neg1} !== {32'h4, 1'b1}) begin errors++;
      $display("FAIL sw_sm: got %h neg=%b want 00000004 neg=1", imm1, neg1); end
  endtask

  task automatic test_imm_mode1;
    send(W_BEQ);
    checks++; if ({tipo1, rd1, rs1_1, rs2_1, imm1, neg1} !== {3'b011, 5'd0, 5'd1, 5'd2, 32'h8, 1'b1}) begin errors++;
      $display("FAIL beq_sm: got tipo=%b rd=%0d rs1=%0d rs2=%0d imm=%h neg=%b", tipo1, rd1, rs1_1, rs2_1, imm1, neg1); end
    checks++; if (imm0 !== 32'hFFFFFFF8) begin errors++;
      $display("FAIL beq_tc: got %h want fffffff8", imm0); end
    send(W_JAL);
    checks++; if ({tipo1, rd1, rs1_1, f3_1, imm1, neg1, imm0} !== {3'b101, 5'd1, 5'd0, 3'd0, 32'h800, 1'b0, 32'h800}) begin errors++;
      $display("FAIL jal: got tipo=%b rd=%0d imm_sm=%h neg=%b imm_tc=%h", tipo1, rd1, imm1, neg1, imm0); end
  endtask

  task automatic test_unknown;
    send(32'h0000007F);
    checks++; if ({tipo0, imm0, neg0, op0} !== {3'b111, 32'h0, 1'b0, 7'h7F}) begin errors++;
      $display("FAIL unk7f: got tipo=%b imm=%h neg=%b op=%h", tipo0, imm0, neg0, op0); end
`ifdef DECODIFICACAO_ILLEGAL_EN
    checks++; if (ill0 !== 1'b1) begin errors++; $display("FAIL unk_illegal: got %b want 1", ill0); end
`endif
    send(32'hFFFFFFFF);
    checks++; if ({tipo1, rd1, rs1_1, rs2_1, f7_1, imm1, neg1} !== {3'b111, 5'd0, 5'd0, 5'd0, 7'd0, 32'h0, 1'b0}) begin errors++;
      $display("FAIL unkff: got tipo=%b rd=%0d rs1=%0d rs2=%0d f7=%h imm=%h neg=%b", tipo1, rd1, rs1_1, rs2_1, f7_1, imm1, neg1); end
  endtask

  task automatic test_illegal_r;
    send(W_SUBB);
    checks++; if ({tipo0, f3_0, f7_0} !== {3'b000, 3'd1, 7'h20}) begin errors++;
      $display("FAIL r_bad_fields: got tipo=%b f3=%0d f7=%h", tipo0, f3_0, f7_0); end
`ifdef DECODIFICACAO_ILLEGAL_EN
    checks++; if (ill0 !== 1'b1) begin errors++; $display("FAIL r_illegal: got %b want 1", ill0); end
    send(W_ADD);
    checks++; if (ill0 !== 1'b0) begin errors++; $display("FAIL add_legal: got %b want 0", ill0); end
`endif
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL drain: out_valid got %b want 0", vld0); end
  endtask

  task automatic test_back_to_back;
    mon_q.delete();
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_instr = W_ADDI;
    @(posedge clk); #1;
    checks++; if ({vld0, rd0, rdy0} !== {1'b1, 5'd1, 1'b1}) begin errors++;
      $display("FAIL bp_first: got v=%b rd=%0d rdy=%b", vld0, rd0, rdy0); end
    @(negedge clk); in_instr = W_LUI;
    @(posedge clk); #1;
    checks++; if ({rdy0, rd0} !== {1'b0, 5'd1}) begin errors++;
      $display("FAIL bp_second: got rdy=%b rd=%0d want rdy=0 rd=1", rdy0, rd0); end
    @(negedge clk); in_instr = W_ADD;
    @(posedge clk); #1;
    checks++; if ({vld0, rdy0, rd0} !== {1'b1, 1'b0, 5'd1}) begin errors++;
      $display("FAIL bp_hold: got v=%b rdy=%b rd=%0d", vld0, rdy0, rd0); end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if ({vld0, rdy0, rd0} !== {1'b1, 1'b1, 5'd5}) begin errors++;
      $display("FAIL bp_drain1: got v=%b rdy=%b rd=%0d want 1 1 5", vld0, rdy0, rd0); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if ({vld0, rd0} !== {1'b1, 5'd3}) begin errors++;
      $display("FAIL bp_drain2: got v=%b rd=%0d want 1 3", vld0, rd0); end
    @(posedge clk); #1;
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL bp_empty: out_valid got %b want 0", vld0); end
    checks++; if (mon_q.size() != 3 || mon_q[0] !== 5'd1 || mon_q[1] !== 5'd5 || mon_q[2] !== 5'd3) begin errors++;
      $display("FAIL bp_order: got %0d words, want rd sequence 1,5,3", mon_q.size()); end
  endtask

  task automatic test_flush;
    mon_q.delete();
    fill_both;
    checks++; if ({vld0, rdy0} !== 2'b10) begin errors++;
      $display("FAIL fl_full: got v=%b rdy=%b want 1 0", vld0, rdy0); end
    @(negedge clk); flush = 1'b1; in_instr = W_ADD;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if ({vld0, rdy0, rd0} !== {1'b0, 1'b1, 5'd1}) begin errors++;
      $display("FAIL fl_clear: got v=%b rdy=%b rd=%0d want 0 1 1", vld0, rdy0, rd0); end
    @(negedge clk); out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (vld0 !== 1'b0 || mon_q.size() != 0) begin errors++;
      $display("FAIL fl_drop: got v=%b words=%0d want 0 0", vld0, mon_q.size()); end
  endtask

  task automatic test_reset_midstream;
    fill_both;
    @(negedge clk); in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({vld0, rdy0, tipo0, rd0} !== {1'b0, 1'b1, 3'b111, 5'd0}) begin errors++;
      $display("FAIL rst_async: got v=%b rdy=%b tipo=%b rd=%0d", vld0, rdy0, tipo0, rd0); end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if ({vld0, rdy0} !== 2'b01) begin errors++;
      $display("FAIL rst_after: got v=%b rdy=%b want 0 1", vld0, rdy0); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    #12;
    test_reset;
    @(negedge clk); rst_n = 1'b1;
    test_formats;
    test_imm_mode1;
    test_unknown;
    test_illegal_r;
    test_back_to_back;
    test_flush;
    test_reset_midstream;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
